// File: rtl/ghost_chase.sv
// Single-ghost movement controller: each step tick moves the ghost one axis toward
// Pac-Man (CHASE) or a fixed corner (SCATTER); modes alternate on tick-count timers.
module ghost_chase #(
  parameter int STEP        = 4,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 608,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 448,
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 240,
  parameter int SCAT_X      = 608,
  parameter int SCAT_Y      = 0,
  parameter int SCAT_TICKS  = 20,
  parameter int CHASE_TICKS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_en,
  input  logic       freeze,
  input  logic       restart,
  input  logic [9:0] pac_x,
  input  logic [9:0] pac_y,
  output logic [9:0] ghost_x,
  output logic [8:0] ghost_y,
  output logic       mode,
  output logic       moved
);

  localparam int TMAX = (SCAT_TICKS > CHASE_TICKS) ? SCAT_TICKS : CHASE_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic signed [10:0] XLO  = 11'(X_MIN);
  localparam logic signed [10:0] XHI  = 11'(X_MAX);
  localparam logic signed [10:0] YLO  = 11'(Y_MIN);
  localparam logic signed [10:0] YHI  = 11'(Y_MAX);
  localparam logic signed [10:0] STPW = 11'(STEP);

  typedef enum logic [1:0] {S_SCATTER, S_CHASE, S_HALT} state_t;

  typedef struct packed {
    logic signed [10:0] x;
    logic signed [10:0] y;
  } pos_t;

  function automatic logic signed [10:0] clamp11(input logic signed [10:0] v,
                                                 input logic signed [10:0] lo,
                                                 input logic signed [10:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  state_t          r_state;
  logic [TW-1:0]   r_tmr;
  logic [9:0]      r_gx;
  logic [8:0]      r_gy;
  logic            r_mode;
  logic            r_moved;

  pos_t               w_tgt;
  pos_t               w_cur;
  logic signed [10:0] w_dx, w_dy, w_adx, w_ady;
  logic               w_use_x;
  logic signed [10:0] w_d, w_ad, w_amt, w_c, w_nxt;
  logic               w_chg;
  logic [9:0]         w_nx;
  logic [8:0]         w_ny;
  logic               w_last;

  // Target and single-axis step, all in 11-bit signed so no intermediate wraps.
  always_comb begin
    w_tgt.x = (r_state == S_CHASE) ? $signed({1'b0, pac_x}) : 11'(SCAT_X);
    w_tgt.y = (r_state == S_CHASE) ? $signed({1'b0, pac_y}) : 11'(SCAT_Y);
    w_tgt.x = clamp11(w_tgt.x, XLO, XHI);
    w_tgt.y = clamp11(w_tgt.y, YLO, YHI);
    w_cur.x = $signed({1'b0, r_gx});
    w_cur.y = $signed({2'b00, r_gy});
    w_dx    = w_tgt.x - w_cur.x;
    w_dy    = w_tgt.y - w_cur.y;
    w_adx   = (w_dx < 0) ? -w_dx : w_dx;
    w_ady   = (w_dy < 0) ? -w_dy : w_dy;
    w_use_x = (w_adx >= w_ady);
    w_d     = w_use_x ? w_dx : w_dy;
    w_ad    = w_use_x ? w_adx : w_ady;
    w_c     = w_use_x ? w_cur.x : w_cur.y;
    w_amt   = (w_ad < STPW) ? w_ad : STPW;
    w_nxt   = (w_d < 0) ? (w_c - w_amt) : (w_c + w_amt);
    w_nxt   = w_use_x ? clamp11(w_nxt, XLO, XHI) : clamp11(w_nxt, YLO, YHI);
    w_chg   = (w_nxt != w_c);
    w_nx    = w_use_x ? 10'(w_nxt) : r_gx;
    w_ny    = w_use_x ? r_gy : 9'(w_nxt);
  end

  assign w_last = (r_state == S_SCATTER) ? (r_tmr == TW'(SCAT_TICKS - 1))
                                         : (r_tmr == TW'(CHASE_TICKS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_SCATTER;
      r_tmr   <= '0;
      r_gx    <= 10'(X_INIT);
      r_gy    <= 9'(Y_INIT);
      r_mode  <= 1'b0;
      r_moved <= 1'b0;
    end else if (restart) begin
      r_state <= freeze ? S_HALT : S_SCATTER;
      r_tmr   <= '0;
      r_gx    <= 10'(X_INIT);
      r_gy    <= 9'(Y_INIT);
      r_mode  <= 1'b0;
      r_moved <= 1'b0;
    end else if (freeze) begin
      r_state <= S_HALT;
      r_mode  <= 1'b0;
      r_moved <= 1'b0;
    end else if (r_state == S_HALT) begin
      // Leaving HALT consumes the edge; no move even with step_en high.
      r_state <= S_SCATTER;
      r_tmr   <= '0;
      r_mode  <= 1'b0;
      r_moved <= 1'b0;
    end else if (step_en) begin
      r_gx    <= w_nx;
      r_gy    <= w_ny;
      r_moved <= w_chg;
      if (w_last) begin
        r_tmr   <= '0;
        r_state <= (r_state == S_SCATTER) ? S_CHASE : S_SCATTER;
        r_mode  <= (r_state == S_SCATTER);
      end else begin
        r_tmr   <= r_tmr + TW'(1);
      end
    end else begin
      r_moved <= 1'b0;
    end
  end

  assign ghost_x = r_gx;
  assign ghost_y = r_gy;
  assign mode    = r_mode;
  assign moved   = r_moved;

endmodule

// File: tb/tb_ghost_chase.sv
// Directed bench for ghost_chase: hand-computed positions through scatter/chase
// phases, freeze/restart priority, target clamping and asynchronous reset.
module tb_ghost_chase;
  logic       clk = 1'b0;
  logic       rst, step_en, freeze, restart;
  logic [9:0] pac_x, pac_y;
  logic [9:0] ghost_x;
  logic [8:0] ghost_y;
  logic       mode, moved;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ghost_chase dut (
    .clk(clk), .rst(rst), .step_en(step_en), .freeze(freeze), .restart(restart),
    .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .mode(mode), .moved(moved)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input int x, input int y, input int m, input int mv);
    chk({tag, ".x"},     32'(ghost_x), 32'(x));
    chk({tag, ".y"},     32'(ghost_y), 32'(y));
    chk({tag, ".mode"},  32'(mode),    32'(m));
    chk({tag, ".moved"}, 32'(moved),   32'(mv));
  endtask

  // One step_en pulse; returns on the following negedge with outputs updated.
  task automatic tick();
    @(negedge clk) step_en = 1'b1;
    @(negedge clk) step_en = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b0; step_en = 1'b0; freeze = 1'b0; restart = 1'b0;
    pac_x = '0; pac_y = '0;
    #12;
    chk_st("reset", 320, 240, 0, 0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle.moved", 32'(moved), 32'd0);
    end
    chk_st("idle", 320, 240, 0, 0);

    // SCATTER toward (608,0): dx=288 >= |dy|=240 so X moves first
    tick();
    chk_st("scat1", 324, 240, 0, 1);
    @(negedge clk);
    chk("scat1.pulse_end", 32'(moved), 32'd0);
    ticks(18);
    chk_st("scat19", 384, 228, 0, 1);
    tick();
    chk_st("scat20", 384, 224, 1, 1);

    // CHASE axis choice and no-overshoot
    pac_x = 10'd386; pac_y = 10'd424;
    tick();
    chk_st("chase_y", 384, 228, 1, 1);
    pac_x = 10'd386; pac_y = 10'd228;
    tick();
    chk_st("chase_x2", 386, 228, 1, 1);
    tick();
    chk_st("chase_hold", 386, 228, 1, 0);

    // freeze beats step_en; leaving HALT swallows the edge
    @(negedge clk) begin freeze = 1'b1; step_en = 1'b1; end
    @(negedge clk) step_en = 1'b0;
    chk_st("freeze", 386, 228, 0, 0);
    @(negedge clk) begin freeze = 1'b0; step_en = 1'b1; end
    @(negedge clk) step_en = 1'b0;
    chk_st("unfreeze", 386, 228, 0, 0);
    tick();
    chk_st("post_unfreeze", 386, 224, 0, 1);

    // restart+freeze mid-CHASE
    ticks(19);
    chk("to_chase.mode", 32'(mode), 32'd1);
    tick();
    @(negedge clk) begin restart = 1'b1; freeze = 1'b1; end
    @(negedge clk) restart = 1'b0;
    chk_st("restart_frz", 320, 240, 0, 0);
    tick();
    chk_st("halt_tick", 320, 240, 0, 0);
    @(negedge clk) freeze = 1'b0;
    @(negedge clk);
    chk_st("halt_exit", 320, 240, 0, 0);

    // Long walk to (600,440) across alternating phases
    ticks(20);
    chk_st("walk_s0", 384, 224, 1, 1);
    pac_x = 10'd600; pac_y = 10'd440;
    ticks(60);
    chk_st("walk_c1", 504, 344, 0, 1);
    ticks(20);
    chk_st("walk_s1", 504, 264, 1, 1);
    ticks(60);
    chk_st("walk_c2", 584, 424, 0, 1);
    ticks(20);
    chk_st("walk_s2", 584, 344, 1, 1);
    ticks(28);
    chk_st("walk_c3", 600, 440, 1, 1);

    // Out-of-range pac clamps to (608,448); unclamped it would pick Y
    pac_x = 10'd700; pac_y = 10'd600;
    tick();
    chk_st("clamp1", 604, 440, 1, 1);
    tick();
    chk_st("clamp2", 604, 444, 1, 1);
    tick();
    chk_st("clamp3", 608, 444, 1, 1);
    tick();
    chk_st("clamp4", 608, 448, 1, 1);
    tick();
    chk_st("clamp5", 608, 448, 1, 0);

    // Async reset mid-cycle, right after a move
    @(negedge clk) begin restart = 1'b1; end
    @(negedge clk) restart = 1'b0;
    tick();
    chk_st("pre_rst", 324, 240, 0, 1);
    #2 rst = 1'b0;
    #1 chk_st("async_rst", 320, 240, 0, 0);
    @(negedge clk) rst = 1'b1;
    tick();
    chk_st("post_rst", 324, 240, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
